// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg -- shared definitions for the UART transmit path.
//
// Holds the transmit-FSM state encoding and the TX output-mux select codes.
// The control FSM (uart_tx_fsm) and the downstream registered output mux both
// import this package, so a select code means the same thing on both sides.
//
// Contents:
//   tx_state_e  : FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   SEL_*       : 2-bit output-mux select codes
//   state_sel() : mux select that belongs to a given state
//   state_busy(): whether a given state is part of a frame
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_DATA  = 2'b01;
  localparam logic [1:0] SEL_PAR   = 2'b10;
  localparam logic [1:0] SEL_STOP  = 2'b11;

  // Line level while idle is the same as the stop bit, so IDLE shares SEL_STOP.
  function automatic logic [1:0] state_sel(input tx_state_e s);
    logic [1:0] sel;
    sel = SEL_STOP;
    case (s)
      ST_START:  sel = SEL_START;
      ST_DATA:   sel = SEL_DATA;
      ST_PARITY: sel = SEL_PAR;
      default:   sel = SEL_STOP;
    endcase
    return sel;
  endfunction

  function automatic logic state_busy(input tx_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm -- UART transmit control FSM (one UART bit per clock).
//
// Sequences a frame START -> DATA x DATA_WIDTH -> [PARITY] -> STOP and steers
// the serializer and the TX output mux. A frame is accepted when data_valid is
// high in IDLE or in the STOP cycle of the previous frame, which gives
// back-to-back frames with no idle gap while data_valid stays high.
//
// Ports:
//   CLK        : clock, one UART bit period per cycle
//   RST        : asynchronous active-high reset; aborts any frame in flight
//   data_valid : requester has a frame ready
//   par_en     : frame carries a parity bit (sampled at accept only)
//   ser_ld     : serializer load strobe, high in the accept cycle
//   ser_en     : serializer shift enable, high for every DATA cycle
//   mux_sel    : TX output-mux select (see uart_tx_pkg SEL_* codes)
//   busy       : a frame is in progress
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       data_valid,
  input  logic       par_en,
  output logic       ser_ld,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e        state;
  tx_state_e        state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             par_en_r;
  logic             par_nxt;
  logic             accept;

  // The load strobe has to coincide with the accept cycle so the serializer
  // captures the word the requester is presenting now; it is the only output
  // that depends on inputs, and it is gated by RST so nothing loads in reset.
  assign accept = data_valid && !RST && ((state == ST_IDLE) || (state == ST_STOP));
  assign ser_ld = accept;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    par_nxt   = par_en_r;
    case (state)
      ST_IDLE, ST_STOP: begin
        if (accept) begin
          state_nxt = ST_START;
          par_nxt   = par_en;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt = ST_DATA;
        cnt_nxt   = '0;
      end
      ST_DATA: begin
        if (bit_cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = par_en_r ? ST_PARITY : ST_STOP;
        end else begin
          cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        state_nxt = ST_STOP;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so they are exact decodes of
  // the state register with no combinational path from data_valid/par_en.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      par_en_r <= 1'b0;
      mux_sel  <= SEL_STOP;
      ser_en   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= cnt_nxt;
      par_en_r <= par_nxt;
      mux_sel  <= state_sel(state_nxt);
      ser_en   <= (state_nxt == ST_DATA);
      busy     <= state_busy(state_nxt);
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm -- scoreboard bench for uart_tx_fsm.
//
// Two instances run side by side: DATA_WIDTH=8 (index 0) and DATA_WIDTH=5
// (index 1). The reference model tracks each instance only as "position inside
// the current frame" and derives the expected per-cycle outputs from the frame
// layout: start, DATA_WIDTH data bits, optional parity, stop.
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       dv8, pe8, dv5, pe5;
  logic       ld8, en8, busy8;
  logic       ld5, en5, busy5;
  logic [1:0] mux8, mux5;

  always #5 CLK = ~CLK;

  uart_tx_fsm #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .data_valid(dv8), .par_en(pe8),
    .ser_ld(ld8), .ser_en(en8), .mux_sel(mux8), .busy(busy8)
  );

  uart_tx_fsm #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .data_valid(dv5), .par_en(pe5),
    .ser_ld(ld5), .ser_en(en5), .mux_sel(mux5), .busy(busy5)
  );

  typedef struct {
    int         d;
    int         cyc;
    logic       ld;
    logic [1:0] mux;
    logic       en;
    logic       busy;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   width[2] = '{8, 5};
  int   pos[2]   = '{-1, -1};
  bit   par[2]   = '{1'b0, 1'b0};

  // Reference model: pos = -1 when idle, else the cycle index within the frame.
  task automatic model_cycle(input int d, input logic dv, input logic pe, input logic rst);
    exp_t e;
    int   len;
    e.d    = d;
    e.cyc  = cyc;
    e.ld   = 1'b0;
    e.mux  = 2'b11;
    e.en   = 1'b0;
    e.busy = 1'b0;
    e.cnt  = 0;
    if (rst) begin
      pos[d] = -1;
    end else begin
      len = width[d] + 2 + (par[d] ? 1 : 0);
      if (pos[d] >= 0) begin
        e.busy = 1'b1;
        if (pos[d] == 0)                e.mux = 2'b00;
        else if (pos[d] <= width[d])    e.mux = 2'b01;
        else if (pos[d] == len - 1)     e.mux = 2'b11;
        else                            e.mux = 2'b10;
        e.en  = (pos[d] >= 1) && (pos[d] <= width[d]);
        e.cnt = e.en ? pos[d] - 1 : 0;
      end
      e.ld = dv && ((pos[d] < 0) || (pos[d] == len - 1));
      if (e.ld) begin
        pos[d] = 0;
        par[d] = pe;
      end else if (pos[d] >= 0) begin
        pos[d] = pos[d] + 1;
        if (pos[d] == len) pos[d] = -1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic a_dv8, input logic a_pe8, input logic a_dv5,
                      input logic a_pe5, input logic a_rst);
    @(posedge CLK);
    #1;
    dv8 = a_dv8;
    pe8 = a_pe8;
    dv5 = a_dv5;
    pe5 = a_pe5;
    RST = a_rst;
    cyc = cyc + 1;
    model_cycle(0, a_dv8, a_pe8, a_rst);
    model_cycle(1, a_dv5, a_pe5, a_rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int d, input int cy,
                     input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cy, act, req);
    end
  endtask

  // Monitor: compares every queued expectation against the outputs mid-cycle.
  always @(negedge CLK) begin : monitor
    exp_t        e;
    logic        a_ld, a_en, a_busy;
    logic [1:0]  a_mux;
    logic [31:0] a_cnt;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.d == 0) begin
        a_ld = ld8; a_en = en8; a_busy = busy8; a_mux = mux8;
        a_cnt = 32'(dut8.bit_cnt);
      end else begin
        a_ld = ld5; a_en = en5; a_busy = busy5; a_mux = mux5;
        a_cnt = 32'(dut5.bit_cnt);
      end
      chk("ser_ld",  e.d, e.cyc, 32'(a_ld),   32'(e.ld));
      chk("mux_sel", e.d, e.cyc, 32'(a_mux),  32'(e.mux));
      chk("ser_en",  e.d, e.cyc, 32'(a_en),   32'(e.en));
      chk("busy",    e.d, e.cyc, 32'(a_busy), 32'(e.busy));
      chk("bit_cnt", e.d, e.cyc, a_cnt,       32'(e.cnt));
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    RST = 1'b1;
    dv8 = 1'b0; pe8 = 1'b0; dv5 = 1'b0; pe5 = 1'b0;

    // Reset held with data_valid high: nothing may be accepted.
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Single frame, no parity.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(12);

    // Parity requested at accept, dropped straight afterwards.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(14);

    // data_valid held high across three frames.
    repeat (21) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(12);

    // data_valid pulsed during DATA bit 3 must be ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);

    // Reset at DATA bit 5 with data_valid high, then a clean restart.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(12);

    // Narrow instance: plain frame, then a parity frame.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(9);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Randomized traffic on both instances with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 79) == 0));
    end
    idle(15);

    @(negedge CLK);
    #1;
    chk("queue_drained", 0, cyc, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
